// File: rtl/sd_response_sequencer.sv
// SD-card SPI-mode response sequencer: answers commands with R1 and,
// for CMD17, streams one data block framed by a start token and CRC16.
module sd_response_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_CommandReadFinished,
    input  logic        io_ReadSuccess,
    input  logic [5:0]  io_Command,
    input  logic [31:0] io_CommandArgument,
    input  logic        io_TxReady,
    output logic        io_TxValid,
    output logic [7:0]  io_TxByte,
    output logic        io_MemRead,
    output logic [31:0] io_MemAddr,
    input  logic [7:0]  io_MemData,
    output logic [31:0] io_DataBlockSize,
    output logic        io_Busy
);

    typedef enum logic [3:0] {
        IDLE, NCR, R1, GAP, TOKEN, FETCH, DATA, CRCH, CRCL
    } state_t;

    state_t      state;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        success;
    logic        idle_flag;
    logic        app_flag;
    logic [31:0] count;
    logic [15:0] crc;

    logic        xfer;
    logic [31:0] count_nx;
    logic [15:0] crc_nx;
    logic        param_err;
    logic        crc_err;
    logic        illegal;
    logic        idle_nx;
    logic        app_nx;
    logic [31:0] size_nx;
    logic [7:0]  r1_byte;

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign xfer     = io_TxValid && io_TxReady;
    assign count_nx = count + 32'd1;
    assign crc_nx   = crc16(crc, io_TxByte);
    assign io_Busy  = (state != IDLE);

    // Decode the latched command; earlier branches take priority.
    always_comb begin
        param_err = 1'b0;
        crc_err   = 1'b0;
        illegal   = 1'b0;
        idle_nx   = idle_flag;
        app_nx    = 1'b0;
        size_nx   = io_DataBlockSize;
        if (!success) begin
            crc_err = 1'b1;
        end else if (cmd == 6'd0) begin
            idle_nx = 1'b1;
        end else if (cmd == 6'd55) begin
            app_nx = 1'b1;
        end else if (cmd == 6'd41 && app_flag) begin
            idle_nx = 1'b0;
        end else if (cmd == 6'd16) begin
            if (arg >= 32'd1 && arg <= 32'd512) size_nx = arg;
            else param_err = 1'b1;
        end else if (cmd == 6'd17) begin
            illegal = idle_flag;
        end else begin
            illegal = 1'b1;
        end
        r1_byte = {1'b0, param_err, 2'b00, crc_err, illegal, 1'b0, idle_nx};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            cmd              <= 6'd0;
            arg              <= 32'd0;
            success          <= 1'b0;
            idle_flag        <= 1'b1;
            app_flag         <= 1'b0;
            count            <= 32'd0;
            crc              <= 16'd0;
            io_TxValid       <= 1'b0;
            io_TxByte        <= 8'hFF;
            io_MemRead       <= 1'b0;
            io_MemAddr       <= 32'd0;
            io_DataBlockSize <= 32'd512;
        end else begin
            io_MemRead <= 1'b0;
            unique case (state)
                IDLE: if (io_CommandReadFinished) begin
                    cmd        <= io_Command;
                    arg        <= io_CommandArgument;
                    success    <= io_ReadSuccess;
                    count      <= 32'd0;
                    crc        <= 16'd0;
                    state      <= NCR;
                    io_TxValid <= 1'b1;
                    io_TxByte  <= 8'hFF;
                end
                NCR: if (xfer) begin
                    state            <= R1;
                    io_TxByte        <= r1_byte;
                    idle_flag        <= idle_nx;
                    app_flag         <= app_nx;
                    io_DataBlockSize <= size_nx;
                end
                R1: if (xfer) begin
                    io_TxByte <= 8'hFF;
                    if (cmd == 6'd17 && io_TxByte == 8'h00) begin
                        state <= GAP;
                    end else begin
                        state      <= IDLE;
                        io_TxValid <= 1'b0;
                    end
                end
                GAP: if (xfer) begin
                    state     <= TOKEN;
                    io_TxByte <= 8'hFE;
                end
                TOKEN: if (xfer) begin
                    state      <= FETCH;
                    io_TxValid <= 1'b0;
                    io_MemRead <= 1'b1;
                    io_MemAddr <= arg + count;
                end
                FETCH: state <= DATA;
                DATA: begin
                    // First DATA cycle only captures the memory byte.
                    if (!io_TxValid) begin
                        io_TxByte  <= io_MemData;
                        io_TxValid <= 1'b1;
                    end else if (xfer) begin
                        count <= count_nx;
                        crc   <= crc_nx;
                        if (count_nx < io_DataBlockSize) begin
                            state      <= FETCH;
                            io_TxValid <= 1'b0;
                            io_MemRead <= 1'b1;
                            io_MemAddr <= arg + count_nx;
                        end else begin
                            state     <= CRCH;
                            io_TxByte <= crc_nx[15:8];
                        end
                    end
                end
                CRCH: if (xfer) begin
                    state     <= CRCL;
                    io_TxByte <= crc[7:0];
                end
                CRCL: if (xfer) begin
                    state      <= IDLE;
                    io_TxValid <= 1'b0;
                    io_TxByte  <= 8'hFF;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_response_sequencer.sv
// Directed bench for sd_response_sequencer: R1 codes, block read
// framing and CRC, back-pressure, ignored pulses and mid-read reset.
module tb_sd_response_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_CommandReadFinished = 1'b0;
    logic        io_ReadSuccess = 1'b1;
    logic [5:0]  io_Command = 6'd0;
    logic [31:0] io_CommandArgument = 32'd0;
    logic        io_TxReady = 1'b1;
    logic        io_TxValid;
    logic [7:0]  io_TxByte;
    logic        io_MemRead;
    logic [31:0] io_MemAddr;
    logic [7:0]  io_MemData = 8'h00;
    logic [31:0] io_DataBlockSize;
    logic        io_Busy;

    int compared = 0;
    int mismatched = 0;
    bit bp = 1'b0;
    logic [7:0]  byte_q[$];
    logic [31:0] addr_q[$];
    logic [7:0]  exp_q[$];
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_byte = 8'h00;

    sd_response_sequencer dut (
        .clock(clock), .reset(reset),
        .io_CommandReadFinished(io_CommandReadFinished),
        .io_ReadSuccess(io_ReadSuccess),
        .io_Command(io_Command),
        .io_CommandArgument(io_CommandArgument),
        .io_TxReady(io_TxReady), .io_TxValid(io_TxValid),
        .io_TxByte(io_TxByte), .io_MemRead(io_MemRead),
        .io_MemAddr(io_MemAddr), .io_MemData(io_MemData),
        .io_DataBlockSize(io_DataBlockSize), .io_Busy(io_Busy)
    );

    always #5 clock = ~clock;

    // Storage model: memory[a] = a[7:0], one cycle read latency.
    always @(posedge clock) io_MemData <= io_MemRead ? io_MemAddr[7:0] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && stall_prev) begin
            chk("stall_valid", io_TxValid, 1);
            chk("stall_byte", io_TxByte, stall_byte);
        end
        if (!reset && io_TxValid && io_TxReady) byte_q.push_back(io_TxByte);
        if (!reset && io_MemRead) addr_q.push_back(io_MemAddr);
        stall_prev = !reset && io_TxValid && !io_TxReady;
        stall_byte = io_TxByte;
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            io_TxReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse(input logic [5:0] c, input logic [31:0] a, input logic ok);
        io_Command = c;
        io_CommandArgument = a;
        io_ReadSuccess = ok;
        io_CommandReadFinished = 1'b1;
        step();
        io_CommandReadFinished = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (io_Busy && n < 3000) begin
            step();
            n++;
        end
        chk(tag, io_Busy, 0);
    endtask

    task automatic cmd_r1(input string tag, input logic [5:0] c,
                          input logic [31:0] a, input logic ok, input logic [7:0] r1);
        byte_q.delete();
        addr_q.delete();
        pulse(c, a, ok);
        wait_idle({tag, "_done"});
        chk({tag, "_len"}, byte_q.size(), 2);
        chk({tag, "_ncr"}, byte_q[0], 8'hFF);
        chk({tag, "_r1"}, byte_q[1], r1);
        chk({tag, "_noread"}, addr_q.size(), 0);
    endtask

    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] c = 16'h0000;
        for (int b = 0; b < n; b++)
            for (int i = 7; i >= 0; i--) begin
                logic fb = c[15] ^ ((b >> i) & 1);
                c = c << 1;
                if (fb) c = c ^ 16'h1021;
            end
        return c;
    endfunction

    task automatic run_read(input string tag, input bit inject);
        int n = 0;
        byte_q.delete();
        addr_q.delete();
        pulse(6'd17, 32'h100, 1'b1);
        if (inject) begin
            while (addr_q.size() < 5 && n < 3000) begin
                step();
                n++;
            end
            pulse(6'd0, 32'h0, 1'b1);
        end
        wait_idle({tag, "_done"});
        chk({tag, "_len"}, byte_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), byte_q[i], exp_q[i]);
        chk({tag, "_nread"}, addr_q.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_a%0d", tag, i), addr_q[i], 32'h100 + i);
    endtask

    initial begin
        logic [15:0] c;
        int qlen;
        step();
        step();
        chk("rst_valid", io_TxValid, 0);
        chk("rst_byte", io_TxByte, 8'hFF);
        chk("rst_memread", io_MemRead, 0);
        chk("rst_addr", io_MemAddr, 0);
        chk("rst_busy", io_Busy, 0);
        chk("rst_size", io_DataBlockSize, 512);
        reset = 1'b0;
        step();

        cmd_r1("cmd0", 6'd0, 32'd0, 1'b1, 8'h01);
        cmd_r1("cmd16_big", 6'd16, 32'd2048, 1'b1, 8'h41);
        chk("size_kept", io_DataBlockSize, 512);
        cmd_r1("cmd16_16", 6'd16, 32'd16, 1'b1, 8'h01);
        chk("size_16", io_DataBlockSize, 16);
        cmd_r1("cmd17_idle", 6'd17, 32'h100, 1'b1, 8'h05);
        cmd_r1("cmd5_pre", 6'd5, 32'd0, 1'b1, 8'h05);
        cmd_r1("crc_pre", 6'd0, 32'd0, 1'b0, 8'h09);
        cmd_r1("cmd41_noapp", 6'd41, 32'd0, 1'b1, 8'h05);
        cmd_r1("cmd55", 6'd55, 32'd0, 1'b1, 8'h01);
        cmd_r1("acmd41", 6'd41, 32'd0, 1'b1, 8'h00);
        cmd_r1("cmd5_post", 6'd5, 32'd0, 1'b1, 8'h04);
        cmd_r1("crc_post", 6'd0, 32'd0, 1'b0, 8'h08);

        c = ref_crc(16);
        exp_q = '{8'hFF, 8'h00, 8'hFF, 8'hFE};
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);

        run_read("rd", 1'b0);
        run_read("rd_inj", 1'b1);
        bp = 1'b1;
        run_read("rd_bp", 1'b0);
        bp = 1'b0;
        step();

        byte_q.delete();
        addr_q.delete();
        pulse(6'd17, 32'h100, 1'b1);
        for (int n = 0; n < 3000 && addr_q.size() < 3; n++) step();
        chk("mid_reached", addr_q.size(), 3);
        reset = 1'b1;
        step();
        chk("mid_valid", io_TxValid, 0);
        chk("mid_size", io_DataBlockSize, 512);
        chk("mid_busy", io_Busy, 0);
        chk("mid_memread", io_MemRead, 0);
        qlen = byte_q.size();
        reset = 1'b0;
        repeat (5) step();
        chk("mid_nobytes", byte_q.size(), qlen);
        chk("mid_idle", io_Busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
